// File: rtl/rb_return_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rb_return_sched_pkg
// Brief    : Shared memory-controller constants for read-data return.
// Revision : 1.0 - initial release
// ============================================================================
package rb_return_sched_pkg;

    localparam int c_NUM_REQ = 4;
    localparam int c_TAG_W   = 2;
    localparam int c_DATA_W  = 128;
    localparam int c_RB_W    = 144;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_XFER  = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    function automatic logic [c_NUM_REQ-1:0] tag_onehot(input logic [c_TAG_W-1:0] tag);
        return {{(c_NUM_REQ-1){1'b0}}, 1'b1} << tag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rb_tag_fifo
// Brief    : Synchronous first-word-fall-through FIFO holding requester tags.
// Revision : 1.0 - initial release
// ============================================================================
module rb_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rb_return_sched.sv
`default_nettype none
// ============================================================================
// Module   : rb_return_sched
// Brief    : Returns read-buffer words to the requester owning each command.
// Revision : 1.0 - initial release
// ============================================================================
module rb_return_sched
    import rb_return_sched_pkg::*;
#(
    parameter int BEATS     = 2,
    parameter int TAG_DEPTH = 16,
    parameter int ERR_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    input  logic [c_TAG_W-1:0]         cmd_tag,
    output logic                       cmd_ready,
    input  logic [c_RB_W-1:0]          rb_rd,
    input  logic                       rb_empty,
    input  logic                       rb_single_error,
    input  logic                       rb_double_error,
    output logic                       rb_rden,
    output logic [c_DATA_W-1:0]        ret_data,
    output logic [c_NUM_REQ-1:0]       ret_valid,
    output logic                       ret_last,
    output logic                       ret_err,
    input  logic [c_NUM_REQ-1:0]       ret_ready,
    output logic [ERR_W-1:0]           se_count,
    output logic                       de_flag,
    output logic                       orphan,
    output logic [$clog2(TAG_DEPTH):0] outstanding
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(TAG_DEPTH) + 1;
    localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [1:0]         r_state;
    logic [BEAT_W-1:0]  r_beat;
    logic [c_TAG_W-1:0] r_out_tag;
    logic [c_TAG_W-1:0] w_head_tag;
    logic [CNT_W-1:0]   w_count;
    logic               w_tag_full;
    logic               w_tag_empty;
    logic               w_push;
    logic               w_rden;
    logic               w_last_beat;
    logic               w_tag_pop;
    logic               w_out_free;
    logic               w_more;
    logic               w_unused_rb;

    assign w_unused_rb = ^rb_rd[c_RB_W-1:c_DATA_W];

    assign cmd_ready   = ~reset & ~w_tag_full;
    assign w_push      = cmd_valid & cmd_ready;
    // Output stage frees on its own requester's ready, so a pending last beat
    // of one command is never overwritten by the next command's first beat.
    assign w_out_free  = (ret_valid == '0) | ret_ready[r_out_tag];
    assign w_last_beat = (r_beat == c_LAST_BEAT);
    assign w_tag_pop   = (r_state == c_ST_XFER) & w_rden & w_last_beat;
    assign w_more      = (w_count > CNT_W'(1)) | w_push;
    assign rb_rden     = w_rden;
    assign outstanding = w_count;

    always_comb begin
        w_rden = 1'b0;
        if (!reset) begin
            case (r_state)
                c_ST_XFER:  w_rden = ~rb_empty & w_out_free;
                c_ST_FLUSH: w_rden = ~rb_empty;
                default:    w_rden = 1'b0;
            endcase
        end
    end

    rb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (c_TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (cmd_tag),
        .pop       (w_tag_pop),
        .pop_data  (w_head_tag),
        .full      (w_tag_full),
        .empty     (w_tag_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_beat    <= '0;
            r_out_tag <= '0;
            ret_data  <= '0;
            ret_valid <= '0;
            ret_last  <= 1'b0;
            ret_err   <= 1'b0;
            se_count  <= '0;
            de_flag   <= 1'b0;
            orphan    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_tag_empty) begin
                        r_state <= c_ST_XFER;
                    end else if (!rb_empty) begin
                        r_state <= c_ST_FLUSH;
                    end
                end
                c_ST_XFER: begin
                    if (w_rden) begin
                        if (w_last_beat) begin
                            r_beat <= '0;
                            if (!w_more) begin
                                r_state <= c_ST_IDLE;
                            end
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                c_ST_FLUSH: begin
                    if (rb_empty) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            if (w_rden && (r_state == c_ST_XFER)) begin
                ret_data  <= rb_rd[c_DATA_W-1:0];
                ret_valid <= tag_onehot(w_head_tag);
                r_out_tag <= w_head_tag;
                ret_last  <= w_last_beat;
                ret_err   <= rb_double_error;
            end else if (w_out_free) begin
                ret_valid <= '0;
                ret_last  <= 1'b0;
                ret_err   <= 1'b0;
            end

            if (w_rden) begin
                if (rb_single_error && (se_count != '1)) begin
                    se_count <= se_count + 1'b1;
                end
                if (rb_double_error) begin
                    de_flag <= 1'b1;
                end
                if (r_state == c_ST_FLUSH) begin
                    orphan <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rb_return_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rb_return_sched
// Brief    : Directed and randomized checks of rb_return_sched against a
//            command/word ordering model and a FWFT read-buffer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rb_return_sched;

    localparam int BEATS     = 2;
    localparam int TAG_DEPTH = 16;
    localparam int ERR_W     = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [1:0]       cmd_tag;
    logic             cmd_ready;
    logic [143:0]     rb_rd;
    logic             rb_empty;
    logic             rb_single_error;
    logic             rb_double_error;
    logic             rb_rden;
    logic [127:0]     ret_data;
    logic [3:0]       ret_valid;
    logic             ret_last;
    logic             ret_err;
    logic [3:0]       ret_ready;
    logic [ERR_W-1:0] se_count;
    logic             de_flag;
    logic             orphan;
    logic [4:0]       outstanding;

    always #5 clk = ~clk;

    rb_return_sched #(
        .BEATS     (BEATS),
        .TAG_DEPTH (TAG_DEPTH),
        .ERR_W     (ERR_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_tag         (cmd_tag),
        .cmd_ready       (cmd_ready),
        .rb_rd           (rb_rd),
        .rb_empty        (rb_empty),
        .rb_single_error (rb_single_error),
        .rb_double_error (rb_double_error),
        .rb_rden         (rb_rden),
        .ret_data        (ret_data),
        .ret_valid       (ret_valid),
        .ret_last        (ret_last),
        .ret_err         (ret_err),
        .ret_ready       (ret_ready),
        .se_count        (se_count),
        .de_flag         (de_flag),
        .orphan          (orphan),
        .outstanding     (outstanding)
    );

    typedef struct { logic [127:0] d; bit se; bit de; } word_t;
    typedef struct { logic [1:0] tag; logic [127:0] d; bit last; bit err; } beat_t;

    word_t            rbq[$];
    beat_t            expq[$];
    logic [1:0]       owed[$];
    int               owed_beat;
    logic [ERR_W-1:0] se_exp;
    bit               de_exp;
    bit               orphan_exp;
    int               n_total;
    int               n_pass;
    int               n_fail;
    logic [3:0]       obs_valid;
    logic             obs_last;
    bit               cmd_acc;
    logic [3:0]       seq [6];
    logic             lastseq [6];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_rb();
        if (rbq.size() == 0) begin
            rb_empty        = 1'b1;
            rb_rd           = '0;
            rb_single_error = 1'b0;
            rb_double_error = 1'b0;
        end else begin
            rb_empty        = 1'b0;
            rb_rd           = {16'hA5C3, rbq[0].d};
            rb_single_error = rbq[0].se;
            rb_double_error = rbq[0].de;
        end
    endtask

    // Words belong to accepted commands strictly in order, BEATS per command.
    task automatic push_word(input logic [127:0] d, input bit se, input bit de);
        word_t w;
        beat_t b;
        w.d = d; w.se = se; w.de = de;
        rbq.push_back(w);
        if (se && (se_exp != '1)) se_exp++;
        if (de) de_exp = 1'b1;
        if (owed.size() > 0) begin
            b.tag  = owed[0];
            b.d    = d;
            b.last = (owed_beat == BEATS - 1);
            b.err  = de;
            expq.push_back(b);
            owed_beat++;
            if (owed_beat == BEATS) begin
                owed.delete(0);
                owed_beat = 0;
            end
        end else begin
            orphan_exp = 1'b1;
        end
        update_rb();
    endtask

    task automatic tick();
        logic       rd;
        logic [3:0] oh;
        beat_t      e;
        @(negedge clk);
        rd        = rb_rden;
        obs_valid = ret_valid;
        obs_last  = ret_last;
        cmd_acc   = cmd_valid && cmd_ready;
        if (rb_empty) chk("rden_while_empty", 128'(rb_rden), 128'(0));
        if ((ret_valid & ret_ready) != 4'b0) begin
            if (expq.size() == 0) begin
                chk("unexpected_beat", 128'(ret_valid), 128'(0));
            end else begin
                e  = expq.pop_front();
                oh = 4'b0001 << e.tag;
                chk("beat_valid", 128'(ret_valid), 128'(oh));
                chk("beat_data", ret_data, e.d);
                chk("beat_last", 128'(ret_last), 128'(e.last));
                chk("beat_err", 128'(ret_err), 128'(e.err));
            end
        end
        @(posedge clk);
        #1;
        if (rd && (rbq.size() > 0)) rbq.delete(0);
        update_rb();
    endtask

    task automatic issue_cmd(input logic [1:0] tag);
        cmd_valid = 1'b1;
        cmd_tag   = tag;
        tick();
        cmd_valid = 1'b0;
        if (cmd_acc) owed.push_back(tag);
    endtask

    task automatic drain(input int budget, output int cycles);
        bit done;
        ret_ready = 4'hF;
        cycles    = 0;
        done      = (expq.size() == 0) && (rbq.size() == 0) && (ret_valid == 4'b0);
        while (!done && (cycles < budget)) begin
            tick();
            cycles++;
            done = (expq.size() == 0) && (rbq.size() == 0) && (ret_valid == 4'b0);
        end
        chk("drain_done", 128'(done), 128'(1));
    endtask

    task automatic do_reset();
        ret_ready = 4'h0;
        cmd_valid = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
        chk("rst_rden", 128'(rb_rden), 128'(0));
        chk("rst_ret_valid", 128'(ret_valid), 128'(0));
        chk("rst_ret_last", 128'(ret_last), 128'(0));
        chk("rst_ret_err", 128'(ret_err), 128'(0));
        chk("rst_ret_data", ret_data, 128'(0));
        chk("rst_se_count", 128'(se_count), 128'(0));
        chk("rst_de_flag", 128'(de_flag), 128'(0));
        chk("rst_orphan", 128'(orphan), 128'(0));
        chk("rst_outstanding", 128'(outstanding), 128'(0));
        expq.delete();
        owed.delete();
        owed_beat  = 0;
        se_exp     = '0;
        de_exp     = 1'b0;
        orphan_exp = (rbq.size() > 0);
        foreach (rbq[i]) begin
            if (rbq[i].se && (se_exp != '1)) se_exp++;
            if (rbq[i].de) de_exp = 1'b1;
        end
        reset = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 128'(cmd_ready), 128'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, finish required");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          first;
        int          cnt;
        int          cyc;
        int          r;
        logic [127:0] d0;
        n_total    = 0;
        n_pass     = 0;
        n_fail     = 0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_tag    = 2'd0;
        ret_ready  = 4'h0;
        owed_beat  = 0;
        se_exp     = '0;
        de_exp     = 1'b0;
        orphan_exp = 1'b0;
        update_rb();
        do_reset();

        // Single command, tag 2: two consecutive beats, last on the second.
        ret_ready = 4'hF;
        issue_cmd(2'd2);
        chk("t39_outstanding_1", 128'(outstanding), 128'(1));
        push_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        push_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            seq[i]     = obs_valid;
            lastseq[i] = obs_last;
        end
        first = -1;
        cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            if (seq[i] == 4'b0100) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        chk("t39_beat_count", 128'(cnt), 128'(2));
        chk("t39_first_found", 128'((first >= 0) && (first < 5)), 128'(1));
        if ((first >= 0) && (first < 5)) begin
            chk("t39_consecutive", 128'(seq[first+1]), 128'(4'b0100));
            chk("t39_first_not_last", 128'(lastseq[first]), 128'(0));
            chk("t39_second_last", 128'(lastseq[first+1]), 128'(1));
        end
        chk("t39_outstanding_0", 128'(outstanding), 128'(0));

        // Fill the tag FIFO without data; the 17th command must bounce.
        ret_ready = 4'h0;
        for (int i = 0; i < TAG_DEPTH; i++) issue_cmd(2'($urandom_range(0, 3)));
        chk("t40_cmd_ready_full", 128'(cmd_ready), 128'(0));
        chk("t40_outstanding_16", 128'(outstanding), 128'(16));
        issue_cmd(2'd1);
        chk("t40_17th_not_accepted", 128'(cmd_acc), 128'(0));
        chk("t40_outstanding_still_16", 128'(outstanding), 128'(16));
        for (int i = 0; i < TAG_DEPTH * BEATS; i++)
            push_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        drain(200, cyc);
        chk("t40_one_beat_per_cycle", 128'(cyc <= TAG_DEPTH * BEATS + 4), 128'(1));
        chk("t40_outstanding_0", 128'(outstanding), 128'(0));

        // Requester 1 stalls: head word held, no further pops.
        ret_ready = 4'b1101;
        issue_cmd(2'd1);
        d0 = {$urandom, $urandom, $urandom, $urandom};
        push_word(d0, 1'b0, 1'b0);
        push_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t41_data_held", ret_data, d0);
            chk("t41_valid_held", 128'(ret_valid), 128'(4'b0010));
            chk("t41_no_pop", 128'(rb_rden), 128'(0));
        end
        chk("t41_word_kept", 128'(rbq.size()), 128'(1));
        drain(50, cyc);

        // Error accounting: three corrected, one uncorrectable.
        issue_cmd(2'd3);
        issue_cmd(2'd3);
        push_word({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        push_word({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        push_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
        push_word({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        drain(50, cyc);
        chk("t42_se_count", 128'(se_count), 128'(se_exp));
        chk("t42_se_count_3", 128'(se_count), 128'(3));
        chk("t42_de_flag", 128'(de_flag), 128'(de_exp));

        // Words with no command are flushed without any return.
        chk("t43_orphan_clear", 128'(orphan), 128'(orphan_exp));
        for (int i = 0; i < 3; i++)
            push_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        drain(50, cyc);
        chk("t43_orphan_set", 128'(orphan), 128'(orphan_exp));
        chk("t43_outstanding", 128'(outstanding), 128'(0));

        // Reset after beat 0: the leftover word is flushed as an orphan.
        ret_ready = 4'h0;
        issue_cmd(2'd0);
        push_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        push_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("t44_beat0_loaded", 128'(ret_valid), 128'(4'b0001));
        chk("t44_one_left", 128'(rbq.size()), 128'(1));
        do_reset();
        drain(50, cyc);
        chk("t44_orphan", 128'(orphan), 128'(orphan_exp));
        chk("t44_outstanding", 128'(outstanding), 128'(0));

        // Randomized traffic with random per-requester backpressure.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ret_ready = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (r < 3) begin
                issue_cmd(2'($urandom_range(0, 3)));
            end else begin
                if ((r < 7) && (owed.size() > 0))
                    push_word({$urandom, $urandom, $urandom, $urandom},
                              $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
                tick();
            end
        end
        while (owed.size() > 0)
            push_word({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 7) == 0, 1'b0);
        drain(2000, cyc);
        chk("rnd_outstanding", 128'(outstanding), 128'(0));
        chk("rnd_se_count", 128'(se_count), 128'(se_exp));
        chk("rnd_de_flag", 128'(de_flag), 128'(de_exp));
        chk("rnd_orphan", 128'(orphan), 128'(orphan_exp));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rb_return_sched.md
RB_RETURN_SCHED -- requirements
Module: rb_return_sched

Interface
REQ-001 Parameter BEATS, default 2, meaning read-buffer words returned per read command (1..8).
REQ-002 Parameter TAG_DEPTH, default 16, meaning maximum outstanding read commands (power of 2); BEATS*TAG_DEPTH SHALL be <=512.
REQ-003 Parameter ERR_W, default 16, meaning width of the single-error counter.
REQ-004 Clk  in  1  sole clock; user side of the read buffer.
REQ-005 Reset  in  1  synchronous, active-high.
REQ-006 CmdValid  in  1  read command issued to memory this cycle.
REQ-007 CmdTag  in  2  requester ID owning the command.
REQ-008 CmdReady  out  1  command accepted when CmdValid&CmdReady.
REQ-009 RbRD  in  144  read-buffer head word (first-word-fall-through); [127:0] data.
REQ-010 RbEmpty  in  1  read-buffer empty.
REQ-011 RbSingleError  in  1  corrected error on head word.
REQ-012 RbDoubleError  in  1  uncorrectable error on head word.
REQ-013 RbRDen  out  1  pop read-buffer head.
REQ-014 RetData  out  128  returned data.
REQ-015 RetValid  out  4  one-hot valid per requester.
REQ-016 RetLast  out  1  final beat of a command.
REQ-017 RetErr  out  1  uncorrectable error on this beat.
REQ-018 RetReady  in  4  per-requester accept.
REQ-019 SECount  out  ERR_W  saturating count of corrected errors.
REQ-020 DEFlag  out  1  sticky uncorrectable error seen.
REQ-021 Orphan  out  1  sticky: data arrived with no outstanding command.
REQ-022 Outstanding  out  log2(TAG_DEPTH)+1  commands in tag FIFO.

Function
REQ-023 Accepted commands SHALL push CmdTag into a TAG_DEPTH-entry tag FIFO; CmdReady = tag FIFO not full.
REQ-024 FSM states IDLE, XFER, FLUSH; IDLE->XFER when tag FIFO non-empty; IDLE->FLUSH when tag FIFO empty and RbEmpty=0.
REQ-025 In XFER, RbRDen SHALL assert when RbEmpty=0 and output stage empty or RetReady[head tag]=1 in the same cycle.
REQ-026 Each pop SHALL load output register next cycle: RetData=RbRD[127:0], RetValid=onehot(head tag), RetErr=RbDoubleError, RetLast=(beat==BEATS-1); latency one cycle.
REQ-027 Output stage SHALL hold data and RetValid stable until RetReady of that requester is high.
REQ-028 Beat counter SHALL increment per pop; on pop of beat BEATS-1 the counter clears, the tag FIFO pops, and the FSM returns to IDLE, or stays in XFER if another tag is queued.
REQ-029 Back-to-back commands SHALL sustain one beat per cycle with RetReady held high.
REQ-030 Push and pop of the tag FIFO in one cycle SHALL leave Outstanding unchanged; push when full is ignored.
REQ-031 SECount SHALL increment on each pop with RbSingleError=1 and saturate at all-ones.
REQ-032 DEFlag SHALL set on any pop with RbDoubleError=1; it is cleared only by reset.
REQ-033 In FLUSH, RbRDen SHALL assert each cycle RbEmpty=0, with RetValid=0 and Orphan set; FSM returns to IDLE when RbEmpty=1.
REQ-034 RbRDen SHALL never assert while RbEmpty=1.

Reset
REQ-035 On Reset: FSM=IDLE, tag FIFO empty, beat=0, RetValid=0, RetLast=0, RetErr=0, RetData=0, RbRDen=0, SECount=0, DEFlag=0, Orphan=0, Outstanding=0, CmdReady=0 during Reset and 1 in the following cycle.
REQ-036 Reset mid-transfer SHALL discard the partial command; words remaining in the read buffer then drain via FLUSH.

Structure
REQ-037 State encoding, requester count (4), and the data width (128) SHALL reside in the shared memory-controller package.
REQ-038 The tag FIFO SHALL be a sub-module rb_tag_fifo (synchronous, parameter depth/width, full/empty/count).

Verification
REQ-039 One command tag 2, BEATS=2, two words in buffer, RetReady=4'hF -> RetValid=4'b0100 for two consecutive cycles, RetLast on the second, Outstanding 1->0.
REQ-040 16 commands pushed without data -> CmdReady=0 after the 16th; the 17th is ignored, Outstanding=16.
REQ-041 Tag 1 active, RetReady[1] low for 5 cycles -> RetData held, RbRDen=0, no word lost.
REQ-042 Pop with RbSingleError=1 three times -> SECount=3; with RbDoubleError=1 -> RetErr=1 on that beat, DEFlag=1.
REQ-043 Buffer non-empty with no command -> FLUSH drains all words, RetValid=0, Orphan=1.
REQ-044 Reset asserted after beat 0 -> all outputs at their reset values; the remaining word flushed and Orphan=1.
